ext_int_conditioner: RTL and testbench

//   Conditions the active-low external interrupt pins (INT0_n, INT1_n, ...) of the 8051-style core.

---
 rtl/ext_int_conditioner.sv | 86 ++++++++
 tb/tb_ext_int_conditioner.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ext_int_conditioner.sv
// Conditions active-low external interrupt pins into per-pin IEx flags (sync, filter, edge/level).
// Glitch filter is built only when EXT_INT_FILTER_EN is defined; otherwise filt follows s2 directly.
module ext_int_conditioner #(
  parameter int NUM_OF_EXT_INT = 2,
  parameter int FILTER_CYCLES  = 4
) (
  input  logic                      clk,
  input  logic                      sync_reset,
  input  logic [NUM_OF_EXT_INT-1:0] ext_int_n,
  input  logic [NUM_OF_EXT_INT-1:0] it_mode,
  input  logic [NUM_OF_EXT_INT-1:0] int_ack,
  input  logic [NUM_OF_EXT_INT-1:0] ie_clr,
  output logic [NUM_OF_EXT_INT-1:0] ie_flag,
  output logic [NUM_OF_EXT_INT-1:0] int_level_mode
);

  logic [NUM_OF_EXT_INT-1:0] s1;
  logic [NUM_OF_EXT_INT-1:0] s2;
  logic [NUM_OF_EXT_INT-1:0] filt;
  logic [NUM_OF_EXT_INT-1:0] filt_d1;
  logic [NUM_OF_EXT_INT-1:0] fall;

  // The controller is always fed in level mode; edge handling lives here.
  assign int_level_mode = '1;

  // filt_d1 resets high alongside filt so no false fall follows reset.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      s1      <= '1;
      s2      <= '1;
      filt_d1 <= '1;
    end else begin
      s1      <= ext_int_n;
      s2      <= s1;
      filt_d1 <= filt;
    end
  end

`ifdef EXT_INT_FILTER_EN
  localparam int                CNT_W    = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [NUM_OF_EXT_INT-1:0][CNT_W-1:0] cnt;

  // Any cycle where s2 agrees with filt restarts the run, so only a full stable run flips filt.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      filt <= '1;
      cnt  <= '0;
    end else begin
      for (int i = 0; i < NUM_OF_EXT_INT; i++) begin
        if (s2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          filt[i] <= s2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  assign filt = s2;
`endif

  assign fall = filt_d1 & ~filt;

  // A fall beats a same-cycle clear so an edge is never lost.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      ie_flag <= '0;
    end else begin
      for (int i = 0; i < NUM_OF_EXT_INT; i++) begin
        if (!it_mode[i]) begin
          ie_flag[i] <= ~filt[i];
        end else if (fall[i]) begin
          ie_flag[i] <= 1'b1;
        end else if (int_ack[i] || ie_clr[i]) begin
          ie_flag[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ext_int_conditioner.sv
// Bench for ext_int_conditioner: directed scenarios plus random pin/mode/clear traffic,
// each edge checked against a reference built from pin history and the flag rules.
module tb_ext_int_conditioner;
  localparam int N  = 2;
  localparam int FC = 4;
`ifdef EXT_INT_FILTER_EN
  localparam bit FILT_ON = 1'b1;
`else
  localparam bit FILT_ON = 1'b0;
`endif
  // Edges from the pin first being sampled low to the flag being set.
  localparam int LAT = FILT_ON ? FC + 2 : 2;

  logic         clk = 1'b0;
  logic         sync_reset;
  logic [N-1:0] ext_int_n;
  logic [N-1:0] it_mode;
  logic [N-1:0] int_ack;
  logic [N-1:0] ie_clr;
  logic [N-1:0] ie_flag;
  logic [N-1:0] int_level_mode;

  int compared   = 0;
  int mismatched = 0;

  // Reference: two-sample pin delay, filtered level, previous filtered level, flag.
  logic [N-1:0] m_s1, m_s2, m_filt, m_filt_d, m_flag;
  logic [N-1:0] m_win [FC];

  logic [N-1:0] r_pins, r_mode, r_ack, r_clr;
  logic         r_rst;
  int           run_left [N];

  always #5 clk = ~clk;

  ext_int_conditioner #(.NUM_OF_EXT_INT(N), .FILTER_CYCLES(FC)) dut (
    .clk            (clk),
    .sync_reset     (sync_reset),
    .ext_int_n      (ext_int_n),
    .it_mode        (it_mode),
    .int_ack        (int_ack),
    .ie_clr         (ie_clr),
    .ie_flag        (ie_flag),
    .int_level_mode (int_level_mode)
  );

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // The filtered level flips once the last FC synchronised samples all disagree with it.
  task automatic model_edge();
    logic [N-1:0] fall_v, nflag, nfilt;
    bit           all_diff;
    if (sync_reset) begin
      m_s1 = '1; m_s2 = '1; m_filt = '1; m_filt_d = '1; m_flag = '0;
      for (int w = 0; w < FC; w++) m_win[w] = '1;
    end else begin
      fall_v = m_filt_d & ~m_filt;
      nflag  = m_flag;
      for (int i = 0; i < N; i++) begin
        if (!it_mode[i])                 nflag[i] = ~m_filt[i];
        else if (fall_v[i])              nflag[i] = 1'b1;
        else if (int_ack[i] | ie_clr[i]) nflag[i] = 1'b0;
      end
      if (FILT_ON) begin
        for (int w = FC - 1; w > 0; w--) m_win[w] = m_win[w-1];
        m_win[0] = m_s2;
        nfilt = m_filt;
        for (int i = 0; i < N; i++) begin
          all_diff = 1'b1;
          for (int w = 0; w < FC; w++) if (m_win[w][i] == m_filt[i]) all_diff = 1'b0;
          if (all_diff) nfilt[i] = ~m_filt[i];
        end
      end else begin
        nfilt = m_s1;
      end
      m_filt_d = m_filt;
      m_filt   = nfilt;
      m_s2     = m_s1;
      m_s1     = ext_int_n;
      m_flag   = nflag;
    end
  endtask

  task automatic step(input logic rst, input logic [N-1:0] pins, input logic [N-1:0] mode,
                      input logic [N-1:0] ack, input logic [N-1:0] clr);
    @(negedge clk);
    sync_reset = rst;
    ext_int_n  = pins;
    it_mode    = mode;
    int_ack    = ack;
    ie_clr     = clr;
    @(posedge clk);
    model_edge();
    #1;
    check("model_flag", ie_flag, m_flag);
    check("level_mode", int_level_mode, '1);
  endtask

  initial begin
    sync_reset = 1'b1; ext_int_n = '1; it_mode = 2'b01; int_ack = '0; ie_clr = '0;
    for (int j = 0; j < 3; j++) step(1'b1, 2'b11, 2'b01, 2'b00, 2'b00);
    check("reset_flag", ie_flag, 2'b00);
    for (int j = 0; j < 5; j++) step(1'b0, 2'b11, 2'b01, 2'b00, 2'b00);

    // Edge mode, pin0 held low: flag rises LAT edges after first low sample.
    for (int j = 0; j <= LAT + 4; j++) begin
      step(1'b0, 2'b10, 2'b01, 2'b00, 2'b00);
      check("t1_edge", ie_flag, (j >= LAT) ? 2'b01 : 2'b00);
    end
    for (int j = 0; j < LAT + 2; j++) begin
      step(1'b0, 2'b11, 2'b01, 2'b00, 2'b00);
      check("t1_hold", ie_flag, 2'b01);
    end
    step(1'b0, 2'b11, 2'b01, 2'b01, 2'b00);
    check("t3_ack_clear", ie_flag, 2'b00);

    // Three-cycle glitch: rejected with the filter, latched without it.
    for (int j = 0; j <= LAT + 8; j++) begin
      step(1'b0, (j < 3) ? 2'b10 : 2'b11, 2'b01, 2'b00, 2'b00);
      check("t2_glitch", ie_flag, (!FILT_ON && j >= 2) ? 2'b01 : 2'b00);
    end

    // Clear race: ack alone clears; ack coincident with a new fall loses.
    for (int j = 0; j <= LAT; j++) step(1'b0, 2'b10, 2'b01, 2'b00, 2'b00);
    check("t3_set", ie_flag, 2'b01);
    for (int j = 0; j < LAT + 2; j++) step(1'b0, 2'b11, 2'b01, 2'b00, 2'b00);
    step(1'b0, 2'b11, 2'b01, 2'b01, 2'b00);
    check("t3_ack", ie_flag, 2'b00);
    for (int j = 0; j <= LAT; j++) begin
      step(1'b0, 2'b10, 2'b01, (j == LAT) ? 2'b01 : 2'b00, 2'b00);
      check("t3_race", ie_flag, (j == LAT) ? 2'b01 : 2'b00);
    end
    step(1'b0, 2'b10, 2'b01, 2'b00, 2'b01);
    check("t3_clr_after", ie_flag, 2'b00);
    for (int j = 0; j < 5; j++) begin
      step(1'b0, 2'b10, 2'b01, 2'b00, 2'b00);
      check("t3_held_low", ie_flag, 2'b00);
    end

    // Level mode: a clear cannot stick while the pin stays low.
    for (int j = 0; j < 20; j++) begin
      step(1'b0, 2'b10, 2'b00, 2'b00, (j == 10) ? 2'b01 : 2'b00);
      check("t4_level", ie_flag, 2'b01);
    end
    for (int j = 0; j <= LAT + 3; j++) begin
      step(1'b0, 2'b11, 2'b00, 2'b00, 2'b00);
      check("t4_release", ie_flag, (j >= LAT) ? 2'b00 : 2'b01);
    end

    // Reset during a filter run, pin still low: pipeline refills after release.
    for (int j = 0; j < 3; j++) step(1'b0, 2'b10, 2'b01, 2'b00, 2'b00);
    step(1'b1, 2'b10, 2'b01, 2'b00, 2'b00);
    check("t5_reset", ie_flag, 2'b00);
    for (int j = 1; j <= LAT + 4; j++) begin
      step(1'b0, 2'b10, 2'b01, 2'b00, 2'b00);
      check("t5_refill", ie_flag, (j >= LAT + 1) ? 2'b01 : 2'b00);
    end

    // Mode switches: 1->0 tracks the level, 0->1 synthesises no edge.
    for (int j = 0; j < LAT + 2; j++) begin
      step(1'b0, 2'b11, 2'b01, 2'b00, 2'b00);
      check("t6_hold", ie_flag, 2'b01);
    end
    step(1'b0, 2'b11, 2'b00, 2'b00, 2'b00);
    check("t6_to_level", ie_flag, 2'b00);
    for (int j = 0; j <= LAT; j++) step(1'b0, 2'b10, 2'b00, 2'b00, 2'b00);
    check("t6_level_low", ie_flag, 2'b01);
    for (int j = 0; j < 6; j++) begin
      step(1'b0, 2'b10, 2'b01, 2'b00, 2'b00);
      check("t6_to_edge_hold", ie_flag, 2'b01);
    end
    step(1'b0, 2'b10, 2'b01, 2'b00, 2'b01);
    for (int j = 0; j < 6; j++) begin
      step(1'b0, 2'b10, 2'b01, 2'b00, 2'b00);
      check("t6_no_new_edge", ie_flag, 2'b00);
    end

    // Random traffic on both pins, checked against the reference each edge.
    r_pins = 2'b11;
    r_mode = 2'b01;
    for (int i = 0; i < N; i++) run_left[i] = 0;
    for (int r = 0; r < 600; r++) begin
      for (int i = 0; i < N; i++) begin
        if (run_left[i] == 0) begin
          r_pins[i]   = ~r_pins[i];
          run_left[i] = $urandom_range(1, FC + 4);
        end else begin
          run_left[i]--;
        end
        if ($urandom_range(0, 39) == 0) r_mode[i] = ~r_mode[i];
        r_ack[i] = ($urandom_range(0, 7) == 0);
        r_clr[i] = ($urandom_range(0, 7) == 0);
      end
      r_rst = ($urandom_range(0, 149) == 0);
      step(r_rst, r_pins, r_mode, r_ack, r_clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
